// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_flags
// Brief    : Parametrised single-clock FIFO with FWFT/registered read, level
//            flags, occupancy count and overflow/underflow pulses.
// Revision : 1.0
// ============================================================================
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b0,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  c_DEPTH_INT = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH+1)'(c_DEPTH_INT);
  localparam logic [ADDR_WIDTH:0] c_AF        = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_AE        = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

  if ((AF_LEVEL < 1) || (AF_LEVEL > c_DEPTH_INT)) begin : g_bad_af
    $error("fifo_sync_flags: AF_LEVEL must be in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > c_DEPTH_INT - 1)) begin : g_bad_ae
    $error("fifo_sync_flags: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [c_DEPTH_INT];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  assign full         = (count_q == c_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= c_AF);
  assign almost_empty = (count_q <= c_AE);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_acc = r_en & ~empty;
  assign w_wr_acc = w_en & (~full | w_rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = w_en & ~w_wr_acc;
    unf_d    = r_en & ~w_rd_acc;
    if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not cleared; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) mem_q[wr_ptr_q] <= wdata;
  end

  if (FWFT) begin : g_fwft
    assign rdata  = empty ? '0 : mem_q[rd_ptr_q];
    assign rvalid = ~empty;
  end else begin : g_regread
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= w_rd_acc;
        if (w_rd_acc) rdata_q <= mem_q[rd_ptr_q];
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_flags
// Brief    : Drives a registered-read and an FWFT instance with shared stimulus
//            and compares both against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fifo_sync_flags;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic [DW-1:0] wdata;
  logic          r_en;

  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1;
  logic [AW:0]   count0, count1;
  logic          ovf0, ovf1, unf0, unf1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata0;
  logic          m_rvalid0;
  logic          m_ovf;
  logic          m_unf;
  bit            m_after_reset;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0),
                    .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0));

  fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1),
                    .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  n;
    bit  rd, wr;
    n = q.size();
    if (rst) begin
      q.delete();
      m_rdata0      = '0;
      m_rvalid0     = 1'b0;
      m_ovf         = 1'b0;
      m_unf         = 1'b0;
      m_after_reset = 1'b1;
    end else begin
      rd = r_en && (n != 0);
      wr = w_en && ((n != DEPTH) || rd);
      if (rd) begin
        m_rdata0 = q.pop_front();
        m_rvalid0 = 1'b1;
      end else begin
        m_rvalid0 = 1'b0;
      end
      if (wr) q.push_back(wdata);
      m_ovf = w_en && !wr;
      m_unf = r_en && !rd;
      if (rd || wr) m_after_reset = 1'b0;
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    chk({ctx, ":count0"}, 32'(count0), 32'(n));
    chk({ctx, ":count1"}, 32'(count1), 32'(n));
    chk({ctx, ":full"},   32'({full0, full1}),   32'({2{n == DEPTH}}));
    chk({ctx, ":empty"},  32'({empty0, empty1}), 32'({2{n == 0}}));
    chk({ctx, ":afull"},  32'({af0, af1}),       32'({2{n >= AF}}));
    chk({ctx, ":aempty"}, 32'({ae0, ae1}),       32'({2{n <= AE}}));
    chk({ctx, ":ovf"},    32'({ovf0, ovf1}),     32'({2{m_ovf}}));
    chk({ctx, ":unf"},    32'({unf0, unf1}),     32'({2{m_unf}}));
    chk({ctx, ":rvalid0"}, 32'(rvalid0), 32'(m_rvalid0));
    chk({ctx, ":rdata0"},  32'(rdata0),  32'(m_rdata0));
    chk({ctx, ":rvalid1"}, 32'(rvalid1), 32'(n != 0));
    if (n != 0)
      chk({ctx, ":rdata1"}, 32'(rdata1), 32'(q[0]));
    else if (m_after_reset)
      chk({ctx, ":rdata1_rst"}, 32'(rdata1), 32'(0));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check after it.
  task automatic step(input string ctx, input logic r, input logic we,
                      input logic [DW-1:0] wd, input logic re);
    rst   = r;
    w_en  = we;
    wdata = wd;
    r_en  = re;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; wdata = '0; r_en = 1'b0;
    m_rdata0 = '0; m_rvalid0 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_after_reset = 1'b1;

    // Reset, fill 1..4, drain
    step("reset", 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step("fill", 0, 1, DW'(i), 0);
    for (int i = 0; i < 4; i++)  step("drain", 0, 0, 0, 1);
    step("idle", 0, 0, 0, 0);

    // Overflow when full, rejected word never read
    for (int i = 1; i <= 4; i++) step("fill2", 0, 1, DW'(i), 0);
    step("overflow", 0, 1, 4'd9, 0);
    step("ovf_clear", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("drain2", 0, 0, 0, 1);

    // Underflow on empty, then simultaneous read/write on empty
    step("underflow", 0, 0, 0, 1);
    step("rw_empty", 0, 1, 4'd5, 1);
    step("read5", 0, 0, 0, 1);
    step("idle2", 0, 0, 0, 0);

    // Full with simultaneous read/write, pointers wrap
    for (int i = 1; i <= 4; i++) step("fill3", 0, 1, DW'(i), 0);
    for (int i = 0; i < 6; i++)  step("rw_full", 0, 1, 4'd6, 1);
    for (int i = 0; i < 4; i++)  step("drain3", 0, 0, 0, 1);
    step("unf_tail", 0, 0, 0, 1);

    // FWFT visibility of a single word and its pop
    step("fwft_wr7", 0, 1, 4'd7, 0);
    step("fwft_hold", 0, 0, 0, 0);
    step("fwft_pop", 0, 0, 0, 1);
    step("fwft_idle", 0, 0, 0, 0);

    // Reset mid-operation with a write pending
    for (int i = 1; i <= 3; i++) step("prefill", 0, 1, DW'(i + 10), 0);
    step("mid_reset", 1, 1, 4'd8, 0);
    step("post_reset", 0, 0, 0, 0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic r, we, re;
      logic [DW-1:0] wd;
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      re = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      wd = DW'($urandom);
      step("random", r, we, wd, re);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
